// File: rtl/serial_tc_decode.sv
// Serial two's-complement receiver: rebuilds LSB-first words into sign + magnitude on a one-entry valid/ready buffer.
// Define TC_DEC_OVF_EN to add the sticky `ovf` drop flag.
module serial_tc_decode #(
    parameter int W = 8
) (
    input  logic         t_clk,
    input  logic         r_n,
    input  logic         i,
    input  logic         i_vld,
    input  logic         i_sof,
    input  logic         o_rdy,
    output logic         o_vld,
    output logic         o_sign,
    output logic [W-1:0] o_mag
`ifdef TC_DEC_OVF_EN
    ,
    output logic         ovf
`endif
);

    localparam int CW = $clog2(W);
    localparam logic [CW-1:0] LAST = CW'(W - 1);

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    state_t         state;
    state_t         state_nxt;
    logic [CW-1:0]  cnt;
    logic [CW-1:0]  cnt_nxt;
    logic           seen1;
    logic           seen1_nxt;
    logic [W-1:0]   raw;
    logic [W-1:0]   raw_nxt;
    logic [W-1:0]   neg;
    logic [W-1:0]   neg_nxt;
    logic           done;
    logic           done_sign;
    logic [W-1:0]   done_mag;
    logic           load;
    logic           drain;

    always_ff @(posedge t_clk) begin
        if (!r_n) begin
            state <= IDLE;
            cnt   <= '0;
            seen1 <= 1'b0;
            raw   <= '0;
            neg   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            seen1 <= seen1_nxt;
            raw   <= raw_nxt;
            neg   <= neg_nxt;
        end
    end

    // Bits enter at the MSB and shift right, so after W bits the LSB sits in bit 0.
    // A start-of-frame bit always restarts the word, even mid-word.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        seen1_nxt = seen1;
        raw_nxt   = raw;
        neg_nxt   = neg;
        done      = 1'b0;
        done_sign = 1'b0;
        done_mag  = '0;
        if (i_vld && i_sof) begin
            raw_nxt   = {i, {(W-1){1'b0}}};
            neg_nxt   = {i, {(W-1){1'b0}}};
            seen1_nxt = i;
            cnt_nxt   = CW'(1);
            state_nxt = SHIFT;
        end else if (i_vld && state == SHIFT) begin
            raw_nxt   = {i, raw[W-1:1]};
            neg_nxt   = {i ^ seen1, neg[W-1:1]};
            seen1_nxt = seen1 | i;
            if (cnt == LAST) begin
                done      = 1'b1;
                done_sign = i;
                done_mag  = i ? neg_nxt : raw_nxt;
                cnt_nxt   = '0;
                state_nxt = IDLE;
            end else begin
                cnt_nxt = cnt + 1'b1;
            end
        end
    end

    assign drain = o_vld & o_rdy;
    assign load  = done & (~o_vld | o_rdy);

    always_ff @(posedge t_clk) begin
        if (!r_n) begin
            o_vld  <= 1'b0;
            o_sign <= 1'b0;
            o_mag  <= '0;
        end else if (load) begin
            o_vld  <= 1'b1;
            o_sign <= done_sign;
            o_mag  <= done_mag;
        end else if (drain) begin
            o_vld <= 1'b0;
        end
    end

`ifdef TC_DEC_OVF_EN
    // A word completing into a full, non-draining buffer is lost.
    always_ff @(posedge t_clk) begin
        if (!r_n) begin
            ovf <= 1'b0;
        end else if (done && o_vld && !o_rdy) begin
            ovf <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_serial_tc_decode.sv
// Bench for serial_tc_decode (W=8): directed test-plan scenarios plus random traffic,
// all checked cycle by cycle against an arithmetic reference model.
module tb_serial_tc_decode;

    localparam int W = 8;

    logic         t_clk = 1'b0;
    logic         r_n = 1'b0;
    logic         i = 1'b0;
    logic         i_vld = 1'b0;
    logic         i_sof = 1'b0;
    logic         o_rdy = 1'b0;
    logic         o_vld;
    logic         o_sign;
    logic [W-1:0] o_mag;
`ifdef TC_DEC_OVF_EN
    logic         ovf;
`endif

    int checks = 0;
    int failures = 0;

    // Reference model state: word being collected and the one-entry buffer.
    logic         m_active = 1'b0;
    int           m_cnt = 0;
    logic [W-1:0] m_acc = '0;
    logic         m_vld = 1'b0;
    logic         m_sign = 1'b0;
    logic [W-1:0] m_mag = '0;
    logic         m_ovf = 1'b0;

    serial_tc_decode #(.W(W)) dut (
        .t_clk (t_clk),
        .r_n   (r_n),
        .i     (i),
        .i_vld (i_vld),
        .i_sof (i_sof),
        .o_rdy (o_rdy),
        .o_vld (o_vld),
        .o_sign(o_sign),
        .o_mag (o_mag)
`ifdef TC_DEC_OVF_EN
        ,
        .ovf   (ovf)
`endif
    );

    always #5 t_clk = ~t_clk;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Magnitude of a two's-complement word by plain arithmetic.
    function automatic logic [W-1:0] ref_mag(input logic [W-1:0] w);
        int v;
        v = int'(w);
        if (w[W-1]) return W'((2 ** W) - v);
        return w;
    endfunction

    task automatic model_step(input logic rst_n_v, input logic vld, input logic sof,
                              input logic b, input logic rdy);
        logic complete;
        logic drain;
        complete = 1'b0;
        if (!rst_n_v) begin
            m_active = 1'b0;
            m_cnt    = 0;
            m_acc    = '0;
            m_vld    = 1'b0;
            m_sign   = 1'b0;
            m_mag    = '0;
            m_ovf    = 1'b0;
            return;
        end
        if (vld && sof) begin
            m_acc    = '0;
            m_acc[0] = b;
            m_cnt    = 1;
            m_active = 1'b1;
        end else if (vld && m_active) begin
            m_acc[m_cnt] = b;
            m_cnt++;
            if (m_cnt == W) begin
                complete = 1'b1;
                m_active = 1'b0;
            end
        end
        drain = m_vld && rdy;
        if (complete) begin
            if (!m_vld || drain) begin
                m_vld  = 1'b1;
                m_sign = m_acc[W-1];
                m_mag  = ref_mag(m_acc);
            end else begin
                m_ovf = 1'b1;
            end
        end else if (drain) begin
            m_vld = 1'b0;
        end
    endtask

    // One clock: drive inputs, let the edge happen, advance the model, compare.
    task automatic applyStimulus(input logic rst_n_v, input logic vld, input logic sof,
                                 input logic b, input logic rdy);
        r_n   = rst_n_v;
        i_vld = vld;
        i_sof = sof;
        i     = b;
        o_rdy = rdy;
        @(posedge t_clk);
        model_step(rst_n_v, vld, sof, b, rdy);
        #1;
        checkOutput("o_vld", 32'(o_vld), 32'(m_vld));
        checkOutput("o_sign", 32'(o_sign), 32'(m_sign));
        checkOutput("o_mag", 32'(o_mag), 32'(m_mag));
`ifdef TC_DEC_OVF_EN
        checkOutput("ovf", 32'(ovf), 32'(m_ovf));
`endif
    endtask

    task automatic send_word(input logic [W-1:0] w, input int gap, input logic rdy);
        for (int b = 0; b < W; b++) begin
            applyStimulus(1'b1, 1'b1, b == 0, w[b], rdy);
            for (int g = 0; g < gap; g++) applyStimulus(1'b1, 1'b0, 1'b0, 1'($urandom), rdy);
        end
    endtask

    task automatic expect_word(input string tag, input logic s, input logic [W-1:0] m);
        checkOutput({tag, "_vld"}, 32'(o_vld), 32'd1);
        checkOutput({tag, "_sign"}, 32'(o_sign), 32'(s));
        checkOutput({tag, "_mag"}, 32'(o_mag), 32'(m));
    endtask

    initial begin
        logic [W-1:0] w;
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
        checkOutput("reset_vld", 32'(o_vld), 32'd0);

        send_word(8'hFA, 0, 1'b1);
        expect_word("fa", 1'b1, 8'h06);
        send_word(8'h05, 0, 1'b1);
        expect_word("p05", 1'b0, 8'h05);
        send_word(8'h80, 0, 1'b1);
        expect_word("p80", 1'b1, 8'h80);
        send_word(8'h00, 0, 1'b1);
        expect_word("p00", 1'b0, 8'h00);
        send_word(8'hFF, 0, 1'b1);
        expect_word("pff", 1'b1, 8'h01);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);

        send_word(8'hFA, 3, 1'b1);

        // Backpressure: second word is dropped.
        send_word(8'h03, 0, 1'b0);
        send_word(8'hFE, 0, 1'b0);
        expect_word("hold", 1'b0, 8'h03);
`ifdef TC_DEC_OVF_EN
        checkOutput("ovf_set", 32'(ovf), 32'd1);
`endif
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        checkOutput("drained", 32'(o_vld), 32'd0);

        // Drain and refill on the completion edge.
        send_word(8'h05, 0, 1'b0);
        w = 8'hF6;
        for (int b = 0; b < W; b++) applyStimulus(1'b1, 1'b1, b == 0, w[b], b == W - 1);
        expect_word("refill", 1'b1, 8'h0A);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);

        // Abort a partial word with a fresh start-of-frame.
        for (int b = 0; b < 5; b++) applyStimulus(1'b1, 1'b1, b == 0, 1'($urandom), 1'b1);
        send_word(8'hF6, 0, 1'b1);
        expect_word("abort", 1'b1, 8'h0A);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);

        // Reset mid-word, then with the buffer full.
        for (int b = 0; b < 4; b++) applyStimulus(1'b1, 1'b1, b == 0, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        checkOutput("rst_mid_vld", 32'(o_vld), 32'd0);
        send_word(8'h83, 0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("rst_full_vld", 32'(o_vld), 32'd0);
        checkOutput("rst_full_mag", 32'(o_mag), 32'd0);
        send_word(8'h05, 0, 1'b1);
        expect_word("post_rst", 1'b0, 8'h05);

        // Random traffic against the model.
        for (int c = 0; c < 4000; c++) begin
            logic vld;
            vld = ($urandom_range(0, 9) < 7);
            applyStimulus($urandom_range(0, 299) != 0, vld, vld && ($urandom_range(0, 11) == 0),
                          1'($urandom), ($urandom_range(0, 9) < 6));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/serial_tc_decode.md
# serial_tc_decode

Receive side of the serial two's-complement path. Accepts an LSB-first serial stream of W-bit two's-complement words, one bit per qualified clock, and reconstructs each word on the fly. It presents the word as registered sign + magnitude on a valid/ready output port. The block sits downstream of the serial complementer (`invert`) and converts its bit stream back into parallel unsigned magnitude.

## Interface
Parameters:
- `W`, default 8: word width in bits; legal range is W ≥ 2.

Ports:
- `t_clk`, input, 1: single clock; all state changes on rising edge.
- `r_n`, input, 1: synchronous reset, active-low; sampled on `t_clk` rising edge.
- `i`, input, 1: serial data bit, LSB first.
- `i_vld`, input, 1: `i` and `i_sof` are qualified this cycle.
- `i_sof`, input, 1: with `i_vld`, marks bit 0 (LSB) of a new word.
- `o_rdy`, input, 1: downstream accepts the output word.
- `o_vld`, output, 1: `o_sign`/`o_mag` hold a valid word.
- `o_sign`, output, 1: sign of the word (1 = negative).
- `o_mag`, output, W: unsigned magnitude; `2^(W-1)` for the most-negative input.
- `ovf`, output, 1: sticky drop flag; present only with `TC_DEC_OVF_EN`.

## Operation
- Input FSM has two states, IDLE and SHIFT. There is a bit counter `cnt` of width clog2(W) and two W-bit shift registers: `raw` (input bits) and `neg` (on-the-fly negation).
- Negation rule, per accepted bit b: `neg_bit = b ^ seen1`, then `seen1 |= b`. `seen1` clears at every word start.
- IDLE:
  - `i_vld & i_sof` loads bit 0, sets `cnt=1`, and enters SHIFT.
  - `i_vld` without `i_sof` is ignored.
- SHIFT:
  - Each `i_vld` shifts in one bit and increments `cnt`.
  - `i_vld` low holds all state, with no timeout.
  - `i_vld & i_sof` in SHIFT aborts the partial word without reporting it. That bit is taken as bit 0 of a new word (`cnt=1`, `seen1` recomputed from this bit).
  - Acceptance of bit W-1 completes the word, and the FSM returns to IDLE.
- Completion: `sign = bit W-1`. `mag = sign ? neg : raw`, all W bits. Example for W=8: input `0x80` gives `mag=0x80`.
- Output buffer holds one entry:
  - A completed word loads the buffer if `!o_vld`, or if `o_vld & o_rdy` in the same cycle (drain and refill; `o_vld` stays 1).
  - If the buffer is full and not draining, the completed word is dropped and the buffer is unchanged.
  - `o_vld` clears on `o_vld & o_rdy` when no word completes that cycle.
  - `o_sign`/`o_mag` are stable while `o_vld & !o_rdy`.
- Reset (`r_n=0`) at any point, including mid-word or with the buffer full:
  - FSM goes to IDLE and `cnt=0`, `seen1=0`, `raw=0`, `neg=0`.
  - Outputs: `o_vld=0`, `o_sign=0`, `o_mag=0`, and `ovf=0` when present.
  - The partial word and any buffered word are discarded.

## Timing
- A bit is accepted on the rising edge where `i_vld=1`.
- Latency: bit W-1 is accepted on edge k; `o_vld`, `o_sign` and `o_mag` are valid after edge k, i.e. visible in cycle k+1.
- Minimum word period is W cycles, and back-to-back words are allowed. With `o_rdy` held high, throughput is one word per W cycles with no bubbles.
- `o_rdy` may be high while `o_vld` is low; this has no effect.
- There is no combinational path from inputs to outputs.

## Configuration
- `TC_DEC_OVF_EN` defined:
  - Port `ovf` exists.
  - `ovf` sets on the edge a completed word is dropped and stays 1 until reset.
- Not defined:
  - Port `ovf` and its register are absent.
  - Drop behaviour is identical: the new word is discarded silently.

## Test plan
All scenarios use W=8.
- Reset, then stream `0xFA` (LSB-first, `i_sof` on the first bit, `o_rdy=1`) -> `o_vld=1` one cycle after the 8th bit, with `o_sign=1`, `o_mag=0x06`. Then stream `0x05` -> `o_sign=0`, `o_mag=0x05`.
- Boundaries: `0x80` -> `o_sign=1`, `o_mag=0x80`; `0x00` -> `o_sign=0`, `o_mag=0x00`; `0xFF` -> `o_sign=1`, `o_mag=0x01`.
- Gapped input: `0xFA` with `i_vld` low for 3 cycles between every bit -> same result, `o_vld` exactly once.
- Backpressure: `o_rdy=0`, send `0x03` then `0xFE` back-to-back:
  - Buffer holds `o_mag=3`, `o_sign=0`; `0xFE` is dropped; `ovf=1` when `TC_DEC_OVF_EN` is defined.
  - Then raise `o_rdy` -> one transfer, `o_vld=0` next cycle.
  - Drain-and-refill: with `o_rdy=1` on the completion cycle of the next word, `o_vld` stays 1 and the new value appears.
- Abort: 5 bits of a word, then `i_sof` with `0xF6` -> only `o_sign=1`, `o_mag=0x0A` reported.
- Reset mid-word (after 4 bits) and with the buffer full -> all outputs 0 on the next cycle. The next clean `0x05` decodes correctly.
